uart_tx: RTL and testbench

Command-driven UART transmitter sitting directly downstream of the `uart` command decoder. It consumes the same 7-bit command bus (2-bit opcode plus 5-bit payload), assembles bytes from nibble writes and programs its bit-rate prescaler and frame format from it. Assembled bytes are buffered in a small FIFO and shifted out on a single serial line as 8-bit LSB-first frames, with optional parity and one or two stop bits. The decoder's reset-command strobe performs a synchronous soft reset of this block.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_fifo.sv | 51 +++++
 rtl/uart_tx.sv | 201 ++++++++++++++++++++
 tb/tb_uart_tx.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared command opcodes, transmitter state encoding and defaults
package uart_pkg;

  // Command bus opcodes (in7[1:0])
  localparam logic [1:0] CMD_DATA   = 2'd0;
  localparam logic [1:0] CMD_CONFIG = 2'd1;
  localparam logic [1:0] CMD_PREDIV = 2'd2;
  localparam logic [1:0] CMD_SPARE  = 2'd3;

  // CONFIG payload owned by the decoder; the transmitter leaves it alone
  localparam logic [4:0] CMD_CONFIG_RESET = 5'b11000;

  // Bit-rate divisor after reset: bit period = divisor + 1 clocks
  localparam logic [7:0] DIV_DEFAULT = 8'd9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
  } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous byte FIFO with wrap-bit pointers and flush
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Full is checked before any same-cycle pop, so a push on full is always dropped
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; flush empties the queue in one edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since the pointers gate every read
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - command-driven UART transmitter with byte FIFO and prescaler
module uart_tx #(
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [7:0] DIV_DEFAULT = uart_pkg::DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] in7,
  input  logic       in_valid,
  input  logic       soft_reset,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       empty,
  output logic       overflow
);

  import uart_pkg::*;

  logic [1:0] op;
  logic [4:0] p;
  logic       push_req;

  logic [7:0] div;
  logic       par_en;
  logic       par_odd;
  logic       stop2;
  logic [3:0] lo_nib;
  logic       nib_valid;

  tx_state_t  state;
  tx_state_t  state_next;
  logic [7:0] cnt;
  logic       tick;
  logic [7:0] shreg;
  logic [2:0] bit_idx;
  logic       f_par_en;
  logic       f_stop2;
  logic       f_par_bit;
  logic       do_pop;
  logic       do_shift;
  logic       frame_end;
  logic [7:0] fifo_data;

  assign op   = in7[1:0];
  assign p    = in7[6:2];
  assign tick = (cnt == 8'd0);
  assign busy = (state != ST_IDLE);

  // A high-nibble write completes a byte only when a low nibble is pending
  assign push_req = in_valid && !soft_reset && (op == CMD_DATA) && p[4] && nib_valid;

  uart_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (soft_reset),
    .push      (push_req),
    .push_data ({p[3:0], lo_nib}),
    .pop       (do_pop),
    .pop_data  (fifo_data),
    .full      (full),
    .empty     (empty)
  );

  // Command decode: nibble assembly, frame format, divisor and sticky overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div       <= DIV_DEFAULT;
      par_en    <= 1'b0;
      par_odd   <= 1'b0;
      stop2     <= 1'b0;
      lo_nib    <= 4'd0;
      nib_valid <= 1'b0;
      overflow  <= 1'b0;
    end else if (soft_reset) begin
      div       <= DIV_DEFAULT;
      par_en    <= 1'b0;
      par_odd   <= 1'b0;
      stop2     <= 1'b0;
      lo_nib    <= 4'd0;
      nib_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push_req && full) overflow <= 1'b1;
      if (in_valid) begin
        case (op)
          CMD_DATA: begin
            if (!p[4]) begin
              lo_nib    <= p[3:0];
              nib_valid <= 1'b1;
            end else if (nib_valid) begin
              nib_valid <= 1'b0;
            end
          end
          CMD_CONFIG: begin
            if (p[4:3] == 2'b00) begin
              par_en  <= p[0];
              par_odd <= p[1];
              stop2   <= p[2];
            end
          end
          CMD_PREDIV: begin
            if (!p[4]) div[3:0] <= p[3:0];
            else       div[7:4] <= p[3:0];
          end
          default: ;
        endcase
      end
    end
  end

  // Next-state, pop/shift strobes and serial line level
  always_comb begin
    state_next = state;
    do_pop     = 1'b0;
    do_shift   = 1'b0;
    frame_end  = 1'b0;
    tx         = 1'b1;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          do_pop     = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: begin
        tx = 1'b0;
        if (tick) state_next = ST_DATA;
      end
      ST_DATA: begin
        tx = shreg[0];
        if (tick) begin
          do_shift = 1'b1;
          if (bit_idx == 3'd7) state_next = f_par_en ? ST_PARITY : ST_STOP1;
        end
      end
      ST_PARITY: begin
        tx = f_par_bit;
        if (tick) state_next = ST_STOP1;
      end
      ST_STOP1: begin
        if (tick) begin
          if (f_stop2) state_next = ST_STOP2;
          else         frame_end  = 1'b1;
        end
      end
      ST_STOP2: begin
        if (tick) frame_end = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
    // Back-to-back frames: the next byte is popped on the final stop-bit boundary
    if (frame_end) begin
      if (!empty) begin
        do_pop     = 1'b1;
        state_next = ST_START;
      end else begin
        state_next = ST_IDLE;
      end
    end
  end

  // State register, bit timer and shifter; frame format is frozen at pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= DIV_DEFAULT;
      shreg     <= 8'd0;
      bit_idx   <= 3'd0;
      f_par_en  <= 1'b0;
      f_stop2   <= 1'b0;
      f_par_bit <= 1'b0;
    end else if (soft_reset) begin
      state     <= ST_IDLE;
      cnt       <= DIV_DEFAULT;
      shreg     <= 8'd0;
      bit_idx   <= 3'd0;
      f_par_en  <= 1'b0;
      f_stop2   <= 1'b0;
      f_par_bit <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE || tick) cnt <= div;
      else                          cnt <= cnt - 8'd1;
      if (do_pop) begin
        shreg     <= fifo_data;
        bit_idx   <= 3'd0;
        f_par_en  <= par_en;
        f_stop2   <= stop2;
        f_par_bit <= (^fifo_data) ^ par_odd;
      end else if (do_shift) begin
        shreg   <= {1'b0, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx
module tb_uart_tx;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] in7 = 7'd0;
  logic       in_valid = 1'b0;
  logic       soft_reset = 1'b0;
  logic       tx, busy, full, empty, overflow;

  uart_tx #(.FIFO_DEPTH(4), .DIV_DEFAULT(8'd9)) dut (
    .clk        (clk),
    .reset      (reset),
    .in7        (in7),
    .in_valid   (in_valid),
    .soft_reset (soft_reset),
    .tx         (tx),
    .busy       (busy),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] bits;
    int          nbits;
    int          div0;
    int          div1;
    int          sw;
    bit          b2b;
  } frame_t;

  frame_t exp_q[$];
  int     n_cmp = 0;
  int     n_err = 0;
  int     cyc = 0;
  bit     mon_abort = 1'b0;
  bit     in_frame = 1'b0;
  bit     stray = 1'b0;
  frame_t cur;
  int     bi, ci;
  int     last_end = -100;
  bit     bit_ok;
  logic   bad_val;

  always @(posedge clk) cyc <= cyc + 1;

  // Bits in transmit order: start, data LSB first, optional parity, stop(s)
  function automatic frame_t mk(logic [7:0] d, bit pe, bit pb, bit s2,
                                int d0, int d1, int sw, bit b2b);
    frame_t f;
    int n;
    f.bits = '1;
    f.bits[0] = 1'b0;
    f.bits[8:1] = d;
    n = 9;
    if (pe) begin
      f.bits[9] = pb;
      n = 10;
    end
    f.nbits = n + 1 + int'(s2);
    f.div0 = d0;
    f.div1 = d1;
    f.sw = sw;
    f.b2b = b2b;
    return f;
  endfunction

  task automatic check(string name, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops an expected frame at each start bit and checks every bit level and length
  always @(negedge clk) begin
    if (mon_abort) begin
      exp_q.delete();
      in_frame = 1'b0;
      stray = 1'b0;
      mon_abort = 1'b0;
    end else begin
      if (stray) begin
        if (tx === 1'b1) stray = 1'b0;
      end else if (!in_frame && tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_frame: start bit at cycle %0d with none expected", cyc);
          stray = 1'b1;
        end else begin
          cur = exp_q.pop_front();
          in_frame = 1'b1;
          bi = 0;
          ci = 0;
          bit_ok = 1'b1;
          if (cur.b2b) check_int("b2b_start_cycle", cyc, last_end + 1);
        end
      end
      if (in_frame) begin
        if (tx !== cur.bits[bi]) begin
          bit_ok = 1'b0;
          bad_val = tx;
        end
        ci++;
        if (ci == ((bi < cur.sw) ? cur.div0 : cur.div1) + 1) begin
          n_cmp++;
          if (!bit_ok) begin
            n_err++;
            $display("FAIL frame_bit%0d: got %b expected %b for %0d clocks",
                     bi, bad_val, cur.bits[bi], ((bi < cur.sw) ? cur.div0 : cur.div1) + 1);
          end
          bi++;
          ci = 0;
          bit_ok = 1'b1;
          if (bi == cur.nbits) begin
            in_frame = 1'b0;
            last_end = cyc;
          end
        end
      end
    end
  end

  task automatic cmd(logic [1:0] op, logic [4:0] p);
    in7 = {p, op};
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic push_byte(logic [7:0] d);
    cmd(CMD_DATA, {1'b0, d[3:0]});
    cmd(CMD_DATA, {1'b1, d[7:4]});
  endtask

  task automatic wait_done(int maxc);
    int k;
    k = 0;
    while (!(exp_q.size() == 0 && !in_frame && busy === 1'b0) && k < maxc) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= maxc) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_done: timeout after %0d cycles, %0d frames pending", maxc, exp_q.size());
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_full", full, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_overflow", overflow, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // 0xA5, default divisor 9, start one edge after the push
    exp_q.push_back(mk(8'hA5, 0, 0, 0, 9, 9, 0, 0));
    cmd(CMD_DATA, 5'b00101);
    cmd(CMD_DATA, 5'b11010);
    check("push_empty", empty, 1'b0);
    check("pre_start_tx", tx, 1'b1);
    @(posedge clk);
    #1;
    check("start_tx", tx, 1'b0);
    check("start_busy", busy, 1'b1);
    wait_done(400);

    // Even parity on 0x07 -> parity bit 1
    cmd(CMD_CONFIG, 5'b00001);
    exp_q.push_back(mk(8'h07, 1, 1, 0, 9, 9, 0, 0));
    push_byte(8'h07);
    wait_done(400);

    // Odd parity on 0x07 -> parity bit 0
    cmd(CMD_CONFIG, 5'b00011);
    exp_q.push_back(mk(8'h07, 1, 0, 0, 9, 9, 0, 0));
    push_byte(8'h07);
    wait_done(400);

    // Two stop bits; the decoder's reset payload must not disturb the format
    cmd(CMD_CONFIG, 5'b00100);
    cmd(CMD_CONFIG, 5'b11000);
    exp_q.push_back(mk(8'h07, 0, 0, 1, 9, 9, 0, 0));
    push_byte(8'h07);
    wait_done(400);
    cmd(CMD_CONFIG, 5'b00000);

    // Divisor 3, six bytes into a 4-deep FIFO
    cmd(CMD_PREDIV, 5'b00011);
    cmd(CMD_PREDIV, 5'b10000);
    for (int i = 0; i < 6; i++) begin
      logic [7:0] d;
      d = 8'(8'h11 * (i + 1));
      if (i < 5) exp_q.push_back(mk(d, 0, 0, 0, 3, 3, 0, i > 0));
      push_byte(d);
      if (i == 3) check("full_after_4", full, 1'b0);
      if (i == 4) check("full_after_5", full, 1'b1);
      if (i == 4) check("ovf_after_5", overflow, 1'b0);
      if (i == 5) check("ovf_after_6", overflow, 1'b1);
    end
    wait_done(800);
    check("burst_busy", busy, 1'b0);
    check("burst_empty", empty, 1'b1);
    check("ovf_sticky", overflow, 1'b1);

    // Divisor 0: one clock per bit
    cmd(CMD_PREDIV, 5'b00000);
    exp_q.push_back(mk(8'h3C, 0, 0, 0, 0, 0, 0, 0));
    push_byte(8'h3C);
    wait_done(100);

    // Divisor raised to 16 mid-frame: bit 3 onward lasts 17 clocks
    exp_q.push_back(mk(8'hC3, 0, 0, 0, 0, 16, 3, 0));
    push_byte(8'hC3);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    cmd(CMD_PREDIV, 5'b10001);
    wait_done(400);

    // Soft reset mid-data, with a command in the same cycle that must be discarded
    exp_q.push_back(mk(8'hFF, 0, 0, 0, 16, 16, 0, 0));
    push_byte(8'hFF);
    repeat (17 * 3) @(posedge clk);
    #1;
    check("pre_srst_busy", busy, 1'b1);
    in7 = {5'b00101, CMD_DATA};
    in_valid = 1'b1;
    soft_reset = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    soft_reset = 1'b0;
    mon_abort = 1'b1;
    check("srst_tx", tx, 1'b1);
    check("srst_busy", busy, 1'b0);
    check("srst_empty", empty, 1'b1);
    check("srst_overflow", overflow, 1'b0);
    cmd(CMD_DATA, 5'b11111);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("hi_only_empty", empty, 1'b1);
    check("hi_only_busy", busy, 1'b0);
    exp_q.push_back(mk(8'h5A, 0, 0, 0, 9, 9, 0, 0));
    push_byte(8'h5A);
    wait_done(400);

    // Async reset mid-frame forces the line high without a clock edge
    exp_q.push_back(mk(8'h96, 0, 0, 0, 9, 9, 0, 0));
    push_byte(8'h96);
    repeat (30) @(posedge clk);
    #1;
    check("pre_arst_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("arst_tx", tx, 1'b1);
    check("arst_busy", busy, 1'b0);
    mon_abort = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("final_tx", tx, 1'b1);
    check_int("frames_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
